// File: rtl/ysyx_23060062_mem_arbiter_if.sv
// ysyx_23060062_mem_arbiter_if
// Bundles the IFU, LSU and memory-side signals of the shared memory port.
//   master : the arbiter view. It receives the requests and memory completions
//            and drives the responses and memory commands.
//   slave  : the environment view. It covers the IFU, the LSU and the memory model.
// Groups:
//   ifu_* : read-only fetch requests and responses
//   lsu_* : load/store requests and responses
//   mem_* : the single command/response channel to memory
interface ysyx_23060062_mem_arbiter_if;
  logic        ifu_req;
  logic [31:0] ifu_addr;
  logic        ifu_resp_valid;
  logic [31:0] ifu_rdata;
  logic        ifu_err;

  logic        lsu_req;
  logic        lsu_we;
  logic [31:0] lsu_addr;
  logic [31:0] lsu_wdata;
  logic [3:0]  lsu_wmask;
  logic        lsu_resp_valid;
  logic [31:0] lsu_rdata;
  logic        lsu_err;

  logic        mem_valid;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [3:0]  mem_wmask;
  logic        mem_resp_valid;
  logic [31:0] mem_rdata;

  modport master (
    input  ifu_req, ifu_addr,
    input  lsu_req, lsu_we, lsu_addr, lsu_wdata, lsu_wmask,
    input  mem_resp_valid, mem_rdata,
    output ifu_resp_valid, ifu_rdata, ifu_err,
    output lsu_resp_valid, lsu_rdata, lsu_err,
    output mem_valid, mem_we, mem_addr, mem_wdata, mem_wmask
  );

  modport slave (
    output ifu_req, ifu_addr,
    output lsu_req, lsu_we, lsu_addr, lsu_wdata, lsu_wmask,
    output mem_resp_valid, mem_rdata,
    input  ifu_resp_valid, ifu_rdata, ifu_err,
    input  lsu_resp_valid, lsu_rdata, lsu_err,
    input  mem_valid, mem_we, mem_addr, mem_wdata, mem_wmask
  );
endinterface

// File: rtl/ysyx_23060062_mem_arbiter.sv
// ysyx_23060062_mem_arbiter
// Shares one memory port between the IFU (read-only) and the LSU (read/write).
// The arbiter runs one transaction at a time. Simultaneous requests are granted
// round-robin. A transaction that gets no memory response within TIMEOUT busy
// cycles is aborted and returns err=1.
// Ports:
//   clk : rising-edge clock
//   rst : asynchronous active-high reset
//   bus : ysyx_23060062_mem_arbiter_if.master, which carries the ifu_*, lsu_* and mem_* groups
// Every output is registered. Reset clears all outputs at once, so mem_valid
// drops in the same cycle that rst rises.
module ysyx_23060062_mem_arbiter #(
  parameter int TIMEOUT = 256
) (
  input  logic                               clk,
  input  logic                               rst,
  ysyx_23060062_mem_arbiter_if.master        bus
);

  localparam int              CNT_W    = $clog2(TIMEOUT);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

  typedef enum logic [1:0] {S_IDLE, S_BUSY, S_DONE} state_t;
  typedef enum logic       {SRC_IFU, SRC_LSU}       src_t;

  state_t           state;
  src_t             owner;
  src_t             last;
  logic [CNT_W-1:0] cnt;

  logic        grant_lsu;
  logic        busy_end;
  logic [31:0] rsp_data;
  logic        rsp_err;

  // The LSU wins when it is the only requester, or when both request and the
  // IFU held the previous grant.
  always_comb begin
    grant_lsu = bus.lsu_req && (!bus.ifu_req || (last == SRC_IFU));
    busy_end  = bus.mem_resp_valid || (cnt == CNT_LAST);
    rsp_data  = (bus.mem_resp_valid && !bus.mem_we) ? bus.mem_rdata : 32'h0;
    // A response in the last counted cycle wins over the timeout.
    rsp_err   = !bus.mem_resp_valid;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state              <= S_IDLE;
      owner              <= SRC_IFU;
      last               <= SRC_IFU;
      cnt                <= '0;
      bus.mem_valid      <= 1'b0;
      bus.mem_we         <= 1'b0;
      bus.mem_addr       <= 32'h0;
      bus.mem_wdata      <= 32'h0;
      bus.mem_wmask      <= 4'h0;
      bus.ifu_resp_valid <= 1'b0;
      bus.ifu_rdata      <= 32'h0;
      bus.ifu_err        <= 1'b0;
      bus.lsu_resp_valid <= 1'b0;
      bus.lsu_rdata      <= 32'h0;
      bus.lsu_err        <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          if (bus.ifu_req || bus.lsu_req) begin
            state         <= S_BUSY;
            cnt           <= '0;
            bus.mem_valid <= 1'b1;
            if (grant_lsu) begin
              owner         <= SRC_LSU;
              last          <= SRC_LSU;
              bus.mem_we    <= bus.lsu_we;
              bus.mem_addr  <= bus.lsu_addr;
              bus.mem_wdata <= bus.lsu_wdata;
              // Byte enables only mean something on writes.
              bus.mem_wmask <= bus.lsu_we ? bus.lsu_wmask : 4'h0;
            end else begin
              owner         <= SRC_IFU;
              last          <= SRC_IFU;
              bus.mem_we    <= 1'b0;
              bus.mem_addr  <= bus.ifu_addr;
              bus.mem_wdata <= 32'h0;
              bus.mem_wmask <= 4'h0;
            end
          end
        end

        S_BUSY: begin
          if (busy_end) begin
            state         <= S_DONE;
            bus.mem_valid <= 1'b0;
            bus.mem_we    <= 1'b0;
            bus.mem_wmask <= 4'h0;
            if (owner == SRC_LSU) begin
              bus.lsu_resp_valid <= 1'b1;
              bus.lsu_rdata      <= rsp_data;
              bus.lsu_err        <= rsp_err;
            end else begin
              bus.ifu_resp_valid <= 1'b1;
              bus.ifu_rdata      <= rsp_data;
              bus.ifu_err        <= rsp_err;
            end
          end else begin
            cnt <= cnt + CNT_W'(1);
          end
        end

        S_DONE: begin
          // The requester drops its req on this edge, so nothing is sampled here.
          bus.ifu_resp_valid <= 1'b0;
          bus.lsu_resp_valid <= 1'b0;
          state              <= S_IDLE;
        end

        default: begin
          state <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_ysyx_23060062_mem_arbiter.sv
module tb_ysyx_23060062_mem_arbiter;

  localparam int TOUT = 4;

  typedef struct {
    logic [31:0] addr;
    logic        we;
    logic [31:0] wdata;
    logic [3:0]  wmask;
    int          resp_cyc;
  } ucmd_t;

  typedef struct {
    logic [31:0] addr;
    logic        we;
    logic [31:0] wdata;
    logic [3:0]  wmask;
    int          lat;
    logic [31:0] rdata;
    int          dur;
  } mcmd_t;

  typedef struct {
    bit          is_lsu;
    logic [31:0] rdata;
    logic        err;
  } rsp_t;

  logic clk;
  logic rst;
  bit   stray;
  int   vectors;
  int   misses;
  int   rsp_cnt;

  ucmd_t ifu_q[$];
  ucmd_t lsu_q[$];
  mcmd_t cmd_q[$];
  rsp_t  exp_q[$];

  ysyx_23060062_mem_arbiter_if bus ();

  ysyx_23060062_mem_arbiter #(.TIMEOUT(TOUT)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #300000;
    $display("FAIL watchdog: simulation time limit reached, required finish earlier");
    $fatal(1, "watchdog");
  end

  task automatic issue(input bit is_lsu, input logic [31:0] addr, input logic we,
                       input logic [31:0] wdata, input logic [3:0] wmask, input int resp_cyc,
                       input logic [3:0] m_wmask, input int lat, input logic [31:0] m_rdata,
                       input int dur, input logic [31:0] e_rdata, input logic e_err,
                       input bit want_rsp);
    ucmd_t u;
    mcmd_t m;
    rsp_t  r;
    u = '{addr, we, wdata, wmask, resp_cyc};
    m = '{addr, is_lsu & we, wdata, m_wmask, lat, m_rdata, dur};
    r = '{is_lsu, e_rdata, e_err};
    if (is_lsu) lsu_q.push_back(u);
    else        ifu_q.push_back(u);
    cmd_q.push_back(m);
    if (want_rsp) exp_q.push_back(r);
  endtask

  // Requester: holds req until it samples resp_valid, then immediately moves to
  // its next queued command or drops req. It aborts on reset.
  task automatic run_unit(input bit is_lsu);
    ucmd_t c;
    bit    have;
    bit    got;
    bit    aborted;
    int    cyc;
    if (is_lsu) begin
      bus.lsu_req = 0; bus.lsu_we = 0; bus.lsu_addr = 0; bus.lsu_wdata = 0; bus.lsu_wmask = 0;
    end else begin
      bus.ifu_req = 0; bus.ifu_addr = 0;
    end
    forever begin
      @(posedge clk); #1;
      if (rst || (is_lsu ? (lsu_q.size() == 0) : (ifu_q.size() == 0))) continue;
      c    = is_lsu ? lsu_q.pop_front() : ifu_q.pop_front();
      have = 1;
      while (have) begin
        if (is_lsu) begin
          bus.lsu_req = 1; bus.lsu_we = c.we; bus.lsu_addr = c.addr;
          bus.lsu_wdata = c.wdata; bus.lsu_wmask = c.wmask;
        end else begin
          bus.ifu_req = 1; bus.ifu_addr = c.addr;
        end
        cyc = 0; got = 0; aborted = 0;
        while (!got && !aborted) begin
          @(negedge clk);
          if (rst) aborted = 1;
          else if (is_lsu ? bus.lsu_resp_valid : bus.ifu_resp_valid) got = 1;
          else if (cyc >= 100) begin
            vectors++; misses++;
            $display("FAIL %s_resp_timeout: no response after %0d cycles, required within 100",
                     is_lsu ? "lsu" : "ifu", cyc);
            aborted = 1;
          end else cyc++;
        end
        if (got) begin
          vectors++;
          if (cyc != c.resp_cyc) begin
            misses++;
            $display("FAIL %s_latency addr=%h: got %0d cycles, required %0d",
                     is_lsu ? "lsu" : "ifu", c.addr, cyc, c.resp_cyc);
          end
          @(posedge clk); #1;
        end
        have = 0;
        if (got && !rst && (is_lsu ? (lsu_q.size() != 0) : (ifu_q.size() != 0))) begin
          c    = is_lsu ? lsu_q.pop_front() : ifu_q.pop_front();
          have = 1;
        end else if (is_lsu) bus.lsu_req = 0;
        else                 bus.ifu_req = 0;
      end
    end
  endtask

  initial run_unit(1'b0);
  initial run_unit(1'b1);

  // Memory model and command monitor.
  initial begin : mem_model
    mcmd_t cur;
    bit    busy;
    int    n;
    busy = 0; n = 0;
    cur  = '{32'h0, 1'b0, 32'h0, 4'h0, -1, 32'h0, -1};
    bus.mem_resp_valid = 0;
    bus.mem_rdata      = 0;
    forever begin
      @(negedge clk);
      if (rst) begin
        busy = 0;
        bus.mem_resp_valid = 0;
      end else if (bus.mem_valid) begin
        if (!busy) begin
          busy = 1; n = 0;
          if (cmd_q.size() == 0) begin
            vectors++; misses++;
            $display("FAIL mem_cmd_unexpected: addr=%h issued, required no command", bus.mem_addr);
            cur = '{bus.mem_addr, bus.mem_we, bus.mem_wdata, bus.mem_wmask, -1, 32'h0, -1};
          end else cur = cmd_q.pop_front();
        end else n++;
        vectors++;
        if ({bus.mem_addr, bus.mem_we, bus.mem_wmask} !== {cur.addr, cur.we, cur.wmask} ||
            (cur.we && bus.mem_wdata !== cur.wdata)) begin
          misses++;
          $display("FAIL mem_cmd cyc%0d: got addr=%h we=%b wdata=%h wmask=%h, required addr=%h we=%b wdata=%h wmask=%h",
                   n, bus.mem_addr, bus.mem_we, bus.mem_wdata, bus.mem_wmask,
                   cur.addr, cur.we, cur.wdata, cur.wmask);
        end
        bus.mem_resp_valid = (cur.lat == n);
        bus.mem_rdata      = (cur.lat == n) ? cur.rdata : 32'h0;
      end else begin
        if (busy) begin
          busy = 0;
          if (cur.dur >= 0) begin
            vectors++;
            if (n + 1 != cur.dur) begin
              misses++;
              $display("FAIL mem_valid_len addr=%h: got %0d cycles, required %0d", cur.addr, n + 1, cur.dur);
            end
          end
        end
        bus.mem_resp_valid = stray;
        bus.mem_rdata      = 32'hBAD0_BAD0;
      end
    end
  end

  task automatic check_rsp(input bit is_lsu, input logic [31:0] rdata, input logic err);
    rsp_t e;
    rsp_cnt++;
    vectors++;
    if (exp_q.size() == 0) begin
      misses++;
      $display("FAIL rsp_unexpected: %s response rdata=%h err=%b, required none",
               is_lsu ? "lsu" : "ifu", rdata, err);
    end else begin
      e = exp_q.pop_front();
      if (e.is_lsu != is_lsu || rdata !== e.rdata || err !== e.err) begin
        misses++;
        $display("FAIL rsp: got %s rdata=%h err=%b, required %s rdata=%h err=%b",
                 is_lsu ? "lsu" : "ifu", rdata, err, e.is_lsu ? "lsu" : "ifu", e.rdata, e.err);
      end
    end
  endtask

  initial begin : rsp_mon
    forever begin
      @(negedge clk);
      if (bus.ifu_resp_valid) check_rsp(1'b0, bus.ifu_rdata, bus.ifu_err);
      if (bus.lsu_resp_valid) check_rsp(1'b1, bus.lsu_rdata, bus.lsu_err);
    end
  end

  task automatic drain(input int max_cyc);
    int k;
    k = 0;
    while ((exp_q.size() != 0 || cmd_q.size() != 0 || ifu_q.size() != 0 || lsu_q.size() != 0 ||
            bus.ifu_req || bus.lsu_req) && k < max_cyc) begin
      @(posedge clk);
      k++;
    end
    if (k >= max_cyc) begin
      vectors++; misses++;
      $display("FAIL drain_timeout: %0d responses still pending after %0d cycles, required 0",
               exp_q.size(), k);
    end
    repeat (3) @(posedge clk);
    @(negedge clk);
  endtask

  initial begin : main
    int k;
    int cnt_before;
    vectors = 0; misses = 0; rsp_cnt = 0; stray = 0;
    rst = 1'b1;
    repeat (2) @(negedge clk);
    vectors++;
    if ({bus.mem_valid, bus.mem_we, bus.mem_addr, bus.mem_wdata, bus.mem_wmask,
         bus.ifu_resp_valid, bus.ifu_rdata, bus.ifu_err,
         bus.lsu_resp_valid, bus.lsu_rdata, bus.lsu_err} !== '0) begin
      misses++;
      $display("FAIL reset_outputs: got mem_valid=%b addr=%h wdata=%h ifu_rv=%b lsu_rv=%b, required all 0",
               bus.mem_valid, bus.mem_addr, bus.mem_wdata, bus.ifu_resp_valid, bus.lsu_resp_valid);
    end
    rst = 1'b0;
    @(negedge clk);

    // IFU read, zero-wait memory.
    issue(0, 32'h8000_0000, 0, 32'h0, 4'h0, 2, 4'h0, 0, 32'h0000_0413, 1, 32'h0000_0413, 0, 1);
    drain(60);

    // LSU write, response after three wait cycles; rdata must come back as 0.
    issue(1, 32'h8000_0100, 1, 32'hDEAD_BEEF, 4'h3, 5, 4'h3, 3, 32'h1234_5678, 4, 32'h0, 0, 1);
    drain(60);

    // LSU read: the byte enables must be forced to 0 on the memory side.
    issue(1, 32'h8000_0200, 0, 32'h5555_AAAA, 4'hF, 3, 4'h0, 1, 32'hCAFE_F00D, 2, 32'hCAFE_F00D, 0, 1);
    drain(60);

    // Timeout: memory never answers.
    issue(0, 32'h8000_0300, 0, 32'h0, 4'h0, 5, 4'h0, -1, 32'hFFFF_FFFF, TOUT, 32'h0, 1, 1);
    drain(60);

    // Stray completion while idle is dropped.
    cnt_before = rsp_cnt;
    @(posedge clk); #1 stray = 1;
    @(posedge clk); #1 stray = 0;
    repeat (5) @(posedge clk);
    @(negedge clk);
    vectors++;
    if (rsp_cnt != cnt_before) begin
      misses++;
      $display("FAIL stray_resp: got %0d responses, required %0d", rsp_cnt, cnt_before);
    end

    // Response in the final counted busy cycle wins over the timeout.
    issue(0, 32'h8000_0400, 0, 32'h0, 4'h0, 5, 4'h0, TOUT - 1, 32'h0BAD_C0DE, TOUT, 32'h0BAD_C0DE, 0, 1);
    drain(60);

    // Reset during the 2nd busy cycle of an LSU read (last=LSU before reset).
    issue(1, 32'h8000_0500, 0, 32'h0, 4'h0, 0, 4'h0, -1, 32'h0, -1, 32'h0, 0, 0);
    cnt_before = rsp_cnt;
    k = 0;
    do begin
      @(posedge clk); #1;
      k++;
    end while (!bus.mem_valid && k < 20);
    if (!bus.mem_valid) begin
      vectors++; misses++;
      $display("FAIL reset_test_start: mem_valid=%b, required 1", bus.mem_valid);
    end
    @(posedge clk); #2 rst = 1'b1;
    #1;
    vectors++;
    if (bus.mem_valid !== 1'b0) begin
      misses++;
      $display("FAIL reset_async_mem_valid: got %b, required 0", bus.mem_valid);
    end
    repeat (2) @(negedge clk);
    rst = 1'b0;
    repeat (3) @(negedge clk);
    vectors++;
    if (rsp_cnt != cnt_before) begin
      misses++;
      $display("FAIL reset_no_resp: got %0d responses, required %0d", rsp_cnt, cnt_before);
    end

    // Contention after reset: LSU, then IFU, then LSU again; grants 3 cycles apart.
    issue(1, 32'h8000_0600, 1, 32'h1111_2222, 4'hF, 2, 4'hF, 0, 32'h0000_0009, 1, 32'h0, 0, 1);
    issue(0, 32'h8000_0700, 0, 32'h0, 4'h0, 5, 4'h0, 0, 32'h0000_0077, 1, 32'h0000_0077, 0, 1);
    issue(1, 32'h8000_0800, 0, 32'h0, 4'h0, 5, 4'h0, 0, 32'h0000_0088, 1, 32'h0000_0088, 0, 1);
    drain(100);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, misses);
    $finish;
  end

endmodule
